pifo_set_v2: RTL and testbench

Parametrised successor PIFO set: a registered, sorted array of up to NUM_ELEMENTS (priority, flow) entries with one push port, one pop port and one same-cycle reinsert of the popped head. It adds:
- selectable ordering direction;
- stable FIFO tie-breaking among equal priorities;
- an occupancy count and a per-flow active bitmap derived from array state;
- optional duplicate-flow rejection.

It sits between the flow-enqueue logic and the scheduler's dequeue/re-rank stage.

---
 rtl/pifo_pkg.sv | 23 ++
 rtl/pifo_insert_pos.sv | 44 ++++
 rtl/pifo_set_v2.sv | 180 ++++++++++++++++++
 tb/tb_pifo_set_v2.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared PIFO constants and priority ordering helper
//
// Purpose: default widths and the ordering function for PIFO blocks.
// Contents:
//   DEF_*            default parameter values
//   PRIO_MAX_WIDTH   widest priority prio_before() accepts
//   prio_before(a, b, min_first) - 1 when a strictly precedes b
package pifo_pkg;

  localparam int DEF_NUM_ELEMENTS = 16;
  localparam int DEF_NUM_FLOWS    = 16;
  localparam int DEF_PRIO_WIDTH   = 8;
  localparam int PRIO_MAX_WIDTH   = 32;

  // Strict ordering: equal priorities never precede each other, which is
  // what gives FIFO behaviour among ties.
  function automatic logic prio_before(input logic [PRIO_MAX_WIDTH-1:0] a,
                                       input logic [PRIO_MAX_WIDTH-1:0] b,
                                       input logic                      min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/pifo_insert_pos.sv
// rtl/pifo_insert_pos.sv - sorted insertion position of one candidate
//
// Purpose: compare one candidate priority against the valid part of a
// sorted array.
// Ports:
//   arr_prio     in   priorities of the array, entry 0 is the head
//   arr_count    in   number of valid entries
//   cand_prio    in   candidate priority
//   goes_before  out  bit i set when the candidate lands ahead of valid entry i
//                     (thermometer: set from insert_idx up to arr_count-1)
//   insert_idx   out  index the candidate occupies, behind all equal entries
module pifo_insert_pos
  import pifo_pkg::*;
#(
  parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int PRIO_WIDTH   = DEF_PRIO_WIDTH,
  parameter int MIN_FIRST    = 0,
  parameter int CNT_WIDTH    = $clog2(NUM_ELEMENTS + 1)
) (
  input  logic [NUM_ELEMENTS-1:0][PRIO_WIDTH-1:0] arr_prio,
  input  logic [CNT_WIDTH-1:0]                    arr_count,
  input  logic [PRIO_WIDTH-1:0]                   cand_prio,
  output logic [NUM_ELEMENTS-1:0]                 goes_before,
  output logic [CNT_WIDTH-1:0]                    insert_idx
);

  logic [CNT_WIDTH-1:0] n_before;

  always_comb begin
    goes_before = '0;
    n_before    = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (CNT_WIDTH'(i) < arr_count) begin
        goes_before[i] = prio_before(PRIO_MAX_WIDTH'(cand_prio),
                                     PRIO_MAX_WIDTH'(arr_prio[i]),
                                     MIN_FIRST != 0);
      end
      n_before = n_before + CNT_WIDTH'(goes_before[i]);
    end
    // Array is sorted, so everything not overtaken stays ahead.
    insert_idx = arr_count - n_before;
  end

endmodule

// File: rtl/pifo_set_v2.sv
// rtl/pifo_set_v2.sv - registered sorted PIFO set with pop+reinsert
//
// Purpose: sorted array of (priority, flow) entries, head at index 0, with
// one push, one pop and a same-cycle reinsert of the popped head.
// Optional build macro: PIFO_SET_DUP_REJECT_EN - drop pushes whose flow is
// already active and pulse o__dup_err the next cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i__push_*/o__push_ready    push request; accepted on valid & ready
//   i__pop/o__pop_*            head view; pop fires on i__pop & o__pop_valid
//   i__reinsert_*              reinsert popped head with new priority
//   i__clear_all               synchronous flush, overrides all traffic
//   o__count                   occupancy
//   o__flow_active             per-flow presence bitmap of valid entries
//   o__dup_err                 duplicate-reject pulse (0 without the macro)
module pifo_set_v2
  import pifo_pkg::*;
#(
  parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int NUM_FLOWS    = DEF_NUM_FLOWS,
  parameter int PRIO_WIDTH   = DEF_PRIO_WIDTH,
  parameter int FLOW_WIDTH   = $clog2(NUM_FLOWS),
  parameter int MIN_FIRST    = 0,
  parameter int CNT_WIDTH    = $clog2(NUM_ELEMENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__push_valid,
  input  logic [PRIO_WIDTH-1:0] i__push_priority,
  input  logic [FLOW_WIDTH-1:0] i__push_flow_id,
  output logic                  o__push_ready,
  input  logic                  i__pop,
  output logic                  o__pop_valid,
  output logic [PRIO_WIDTH-1:0] o__pop_priority,
  output logic [FLOW_WIDTH-1:0] o__pop_flow_id,
  input  logic                  i__reinsert_valid,
  input  logic [PRIO_WIDTH-1:0] i__reinsert_priority,
  input  logic                  i__clear_all,
  output logic [CNT_WIDTH-1:0]  o__count,
  output logic [NUM_FLOWS-1:0]  o__flow_active,
  output logic                  o__dup_err
);

  typedef struct packed {
    logic [FLOW_WIDTH-1:0] flow;
    logic [PRIO_WIDTH-1:0] prio;
  } pifo_entry_t;

  localparam int IDX_W = $clog2(NUM_ELEMENTS);

  pifo_entry_t [NUM_ELEMENTS-1:0]           ent_q;
  pifo_entry_t [NUM_ELEMENTS-1:0]           rem;
  pifo_entry_t [NUM_ELEMENTS-1:0]           ent_d;
  logic [NUM_ELEMENTS-1:0][PRIO_WIDTH-1:0]  rem_prio;
  logic [NUM_ELEMENTS-1:0]                  push_before;
  logic [NUM_ELEMENTS-1:0]                  rein_before;
  logic [CNT_WIDTH-1:0]                     count_q;
  logic [CNT_WIDTH-1:0]                     rem_count;
  logic [CNT_WIDTH-1:0]                     count_d;
  logic [CNT_WIDTH-1:0]                     push_idx;
  logic [CNT_WIDTH-1:0]                     rein_idx;
  logic [CNT_WIDTH:0]                       push_slot;
  logic [CNT_WIDTH:0]                       rein_slot;
  logic [CNT_WIDTH:0]                       dst;
  logic                                     pop_valid_q;
  logic                                     is_dup;
  logic                                     pop_fire;
  logic                                     push_fire;
  logic                                     rein_fire;
  logic                                     rein_first;

  assign o__push_ready = (count_q < CNT_WIDTH'(NUM_ELEMENTS)) & ~reset;

  always_comb begin
    o__flow_active = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (CNT_WIDTH'(i) < count_q) o__flow_active[ent_q[i].flow] = 1'b1;
    end
  end

`ifdef PIFO_SET_DUP_REJECT_EN
  // Uses the registered bitmap, so a flow being popped this cycle still blocks.
  assign is_dup = o__flow_active[i__push_flow_id];
`else
  assign is_dup = 1'b0;
`endif

  assign pop_fire  = i__pop & pop_valid_q;
  assign push_fire = i__push_valid & o__push_ready & ~is_dup;
  assign rein_fire = i__reinsert_valid & pop_fire;

  // Array with the head removed; both insert positions are computed here.
  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS - 1; i++) begin
      rem[i] = pop_fire ? ent_q[i+1] : ent_q[i];
    end
    rem[NUM_ELEMENTS-1] = pop_fire ? '0 : ent_q[NUM_ELEMENTS-1];
    for (int i = 0; i < NUM_ELEMENTS; i++) rem_prio[i] = rem[i].prio;
  end

  assign rem_count = count_q - CNT_WIDTH'(pop_fire);
  assign count_d   = rem_count + CNT_WIDTH'(push_fire) + CNT_WIDTH'(rein_fire);

  pifo_insert_pos #(
    .NUM_ELEMENTS(NUM_ELEMENTS), .PRIO_WIDTH(PRIO_WIDTH),
    .MIN_FIRST(MIN_FIRST), .CNT_WIDTH(CNT_WIDTH)
  ) u_push_pos (
    .arr_prio(rem_prio), .arr_count(rem_count), .cand_prio(i__push_priority),
    .goes_before(push_before), .insert_idx(push_idx)
  );

  pifo_insert_pos #(
    .NUM_ELEMENTS(NUM_ELEMENTS), .PRIO_WIDTH(PRIO_WIDTH),
    .MIN_FIRST(MIN_FIRST), .CNT_WIDTH(CNT_WIDTH)
  ) u_rein_pos (
    .arr_prio(rem_prio), .arr_count(rem_count), .cand_prio(i__reinsert_priority),
    .goes_before(rein_before), .insert_idx(rein_idx)
  );

  // Reinsert wins ties with the push; the push only goes first when its
  // priority strictly precedes the reinsert priority.
  assign rein_first = ~prio_before(PRIO_MAX_WIDTH'(i__push_priority),
                                   PRIO_MAX_WIDTH'(i__reinsert_priority),
                                   MIN_FIRST != 0);
  assign rein_slot  = {1'b0, rein_idx} + (CNT_WIDTH+1)'(push_fire & ~rein_first);
  assign push_slot  = {1'b0, push_idx} + (CNT_WIDTH+1)'(rein_fire & rein_first);

  // Scatter: overtaken entries slide back by the number of inserts ahead of
  // them, then the inserted entries fill their slots.
  always_comb begin
    ent_d = rem;
    dst   = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      dst = (CNT_WIDTH+1)'(i)
          + (CNT_WIDTH+1)'(rein_fire & rein_before[i])
          + (CNT_WIDTH+1)'(push_fire & push_before[i]);
      if (dst != (CNT_WIDTH+1)'(i) && dst < (CNT_WIDTH+1)'(NUM_ELEMENTS)) begin
        ent_d[dst[IDX_W-1:0]] = rem[i];
      end
    end
    if (rein_fire && rein_slot < (CNT_WIDTH+1)'(NUM_ELEMENTS)) begin
      ent_d[rein_slot[IDX_W-1:0]] = '{flow: ent_q[0].flow, prio: i__reinsert_priority};
    end
    if (push_fire && push_slot < (CNT_WIDTH+1)'(NUM_ELEMENTS)) begin
      ent_d[push_slot[IDX_W-1:0]] = '{flow: i__push_flow_id, prio: i__push_priority};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q       <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else if (i__clear_all) begin
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      count_q     <= count_d;
      pop_valid_q <= (count_d != '0);
    end
  end

`ifdef PIFO_SET_DUP_REJECT_EN
  logic dup_err_q;
  always_ff @(posedge clk) begin
    if (reset) dup_err_q <= 1'b0;
    else       dup_err_q <= i__push_valid & o__push_ready & is_dup & ~i__clear_all;
  end
  assign o__dup_err = dup_err_q;
`else
  assign o__dup_err = 1'b0;
`endif

  assign o__pop_valid    = pop_valid_q;
  assign o__pop_priority = ent_q[0].prio;
  assign o__pop_flow_id  = ent_q[0].flow;
  assign o__count        = count_q;

endmodule

// File: tb/tb_pifo_set_v2.sv
// tb/tb_pifo_set_v2.sv - self-checking scoreboard bench for pifo_set_v2
module tb_pifo_set_v2;

  localparam int N  = 16;
  localparam int NF = 16;
  localparam int PW = 8;
  localparam int FW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid;
  logic [PW-1:0] push_priority;
  logic [FW-1:0] push_flow_id;
  logic          push_ready;
  logic          pop;
  logic          pop_valid;
  logic [PW-1:0] pop_priority;
  logic [FW-1:0] pop_flow_id;
  logic          reinsert_valid;
  logic [PW-1:0] reinsert_priority;
  logic          clear_all;
  logic [CW-1:0] count;
  logic [NF-1:0] flow_active;
  logic          dup_err;

  always #5 clk = ~clk;

  pifo_set_v2 dut (
    .clk(clk), .reset(reset),
    .i__push_valid(push_valid), .i__push_priority(push_priority),
    .i__push_flow_id(push_flow_id), .o__push_ready(push_ready),
    .i__pop(pop), .o__pop_valid(pop_valid), .o__pop_priority(pop_priority),
    .o__pop_flow_id(pop_flow_id), .i__reinsert_valid(reinsert_valid),
    .i__reinsert_priority(reinsert_priority), .i__clear_all(clear_all),
    .o__count(count), .o__flow_active(flow_active), .o__dup_err(dup_err)
  );

  typedef struct {
    int prio;
    int flow;
  } ent_t;

  ent_t mq[$];     // reference contents, head first
  int   exp_q[$];  // expected popped flows for directed sequences
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_dup  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Largest priority first; new entry goes behind existing equals.
  function automatic void m_insert(input int p, input int f);
    int   idx = mq.size();
    ent_t e;
    e.prio = p;
    e.flow = f;
    for (int i = 0; i < mq.size(); i++) begin
      if (p > mq[i].prio) begin
        idx = i;
        break;
      end
    end
    mq.insert(idx, e);
  endfunction

  function automatic logic [NF-1:0] m_active();
    logic [NF-1:0] a = '0;
    foreach (mq[i]) a[mq[i].flow] = 1'b1;
    return a;
  endfunction

  task automatic check_state(input string tag);
    check_val({tag, "_count"}, 32'(count), 32'(mq.size()));
    check_val({tag, "_pop_valid"}, 32'(pop_valid), 32'(mq.size() > 0));
    check_val({tag, "_push_ready"}, 32'(push_ready), 32'(mq.size() < N));
    check_val({tag, "_flow_active"}, 32'(flow_active), 32'(m_active()));
    check_val({tag, "_dup_err"}, 32'(dup_err), 32'(exp_dup));
    if (mq.size() > 0) begin
      check_val({tag, "_head_prio"}, 32'(pop_priority), 32'(mq[0].prio));
      check_val({tag, "_head_flow"}, 32'(pop_flow_id), 32'(mq[0].flow));
    end
  endtask

  // One clock: drive at negedge, update the model from pre-edge state,
  // check registered outputs just after the rising edge.
  task automatic step(input string tag, input logic pv, input int pp, input int pf,
                      input logic pp_pop, input logic rv, input int rp, input logic clr);
    logic rdy;
    logic dup;
    logic pfire;
    ent_t h;
    @(negedge clk);
    push_valid        = pv;
    push_priority     = PW'(pp);
    push_flow_id      = FW'(pf);
    pop               = pp_pop;
    reinsert_valid    = rv;
    reinsert_priority = PW'(rp);
    clear_all         = clr;
    rdy   = (mq.size() < N);
`ifdef PIFO_SET_DUP_REJECT_EN
    dup   = m_active()[pf];
`else
    dup   = 1'b0;
`endif
    pfire = pp_pop && (mq.size() > 0);
    exp_dup = pv && rdy && dup && !clr;
    if (clr) begin
      mq.delete();
    end else begin
      if (pfire) begin
        h = mq.pop_front();
        check_val({tag, "_popped_flow"}, 32'(pop_flow_id), 32'(h.flow));
        if (exp_q.size() > 0) check_val({tag, "_order"}, 32'(pop_flow_id), 32'(exp_q.pop_front()));
        if (rv) m_insert(rp, h.flow);
      end
      if (pv && rdy && !dup) m_insert(pp, pf);
    end
    @(posedge clk);
    #1;
    push_valid     = 1'b0;
    pop            = 1'b0;
    reinsert_valid = 1'b0;
    clear_all      = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    push_valid = 1'b0; pop = 1'b0; reinsert_valid = 1'b0; clear_all = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    exp_q.delete();
    exp_dup = 1'b0;
    check_val({tag, "_pop_valid"}, 32'(pop_valid), 0);
    check_val({tag, "_count"}, 32'(count), 0);
    check_val({tag, "_push_ready"}, 32'(push_ready), 0);
    check_val({tag, "_flow_active"}, 32'(flow_active), 0);
    check_val({tag, "_dup_err"}, 32'(dup_err), 0);
    check_val({tag, "_head_prio"}, 32'(pop_priority), 0);
    check_val({tag, "_head_flow"}, 32'(pop_flow_id), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    push_valid = 1'b0; push_priority = '0; push_flow_id = '0;
    pop = 1'b0; reinsert_valid = 1'b0; reinsert_priority = '0; clear_all = 1'b0;
    do_reset("reset0");

    // Priority order.
    exp_q = '{2, 3, 1};
    step("po_push1", 1, 10, 1, 0, 0, 0, 0);
    check_val("po_first_valid", 32'(pop_valid), 1);
    step("po_push2", 1, 40, 2, 0, 0, 0, 0);
    step("po_push3", 1, 25, 3, 0, 0, 0, 0);
    check_val("po_count3", 32'(count), 3);
    for (int i = 0; i < 3; i++) step("po_pop", 0, 0, 0, 1, 0, 0, 0);
    check_val("po_empty_valid", 32'(pop_valid), 0);
    step("po_pop_empty", 0, 0, 0, 1, 0, 0, 0);

    // FIFO ties.
    exp_q = '{4, 5, 6};
    for (int f = 4; f <= 6; f++) step("tie_push", 1, 7, f, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("tie_pop", 0, 0, 0, 1, 0, 0, 0);

    // Fill to full, then a rejected 17th push.
    for (int i = 0; i < N; i++) step("fill", 1, $urandom_range(0, 15), i, 0, 0, 0, 0);
    check_val("full_ready", 32'(push_ready), 0);
    step("full_17th", 1, 200, 7, 0, 0, 0, 0);
    check_val("full_count", 32'(count), N);
    // Full: pop+reinsert keeps count, push still blocked.
    step("full_rein", 1, 9, 1, 1, 1, 3, 0);
    for (int i = 0; i < N; i++) step("drain", 0, 0, 0, 1, 0, 0, 0);

    // Reinsert with equal priority to an existing entry.
    step("re_push2", 1, 40, 2, 0, 0, 0, 0);
    step("re_push9", 1, 30, 9, 0, 0, 0, 0);
    exp_q = '{2, 9, 2};
    step("re_pop_rein", 0, 0, 0, 1, 1, 30, 0);
    step("re_pop_a", 0, 0, 0, 1, 0, 0, 0);
    step("re_pop_b", 0, 0, 0, 1, 0, 0, 0);

    // Push and reinsert tie in the same cycle: reinsert lands first.
    step("tie2_push", 1, 50, 1, 0, 0, 0, 0);
    step("tie2_both", 1, 20, 5, 1, 1, 20, 0);
    exp_q = '{1, 5};
    step("tie2_pop_a", 0, 0, 0, 1, 0, 0, 0);
    step("tie2_pop_b", 0, 0, 0, 1, 0, 0, 0);

    // Duplicate flow.
    step("dup_push_a", 1, 12, 3, 0, 0, 0, 0);
    step("dup_push_b", 1, 14, 3, 0, 0, 0, 0);
`ifdef PIFO_SET_DUP_REJECT_EN
    check_val("dup_count", 32'(count), 1);
    check_val("dup_err_pulse", 32'(dup_err), 1);
    step("dup_idle", 0, 0, 0, 0, 0, 0, 0);
    check_val("dup_err_clear", 32'(dup_err), 0);
    step("dup_pop", 0, 0, 0, 1, 0, 0, 0);
`else
    check_val("dup_count", 32'(count), 2);
    step("dup_pop1", 0, 0, 0, 1, 0, 0, 0);
    check_val("dup_active_mid", 32'(flow_active[3]), 1);
    step("dup_pop2", 0, 0, 0, 1, 0, 0, 0);
`endif
    check_val("dup_active_end", 32'(flow_active[3]), 0);

    // Clear overrides push+pop.
    step("clr_push_a", 1, 5, 8, 0, 0, 0, 0);
    step("clr_push_b", 1, 6, 11, 0, 0, 0, 0);
    step("clr_all", 1, 9, 12, 1, 1, 4, 1);
    check_val("clr_count", 32'(count), 0);
    check_val("clr_active", 32'(flow_active), 0);

    // Random traffic with ties, reinserts and occasional clears.
    for (int i = 0; i < 400; i++) begin
      logic pv, pp_pop, rv, clr;
      pv     = ($urandom_range(0, 2) != 0);
      pp_pop = ($urandom_range(0, 2) == 0);
      rv     = pp_pop && (mq.size() > 0) && ($urandom_range(0, 1) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      step("rnd", pv, $urandom_range(0, 15), $urandom_range(0, NF - 1), pp_pop, rv,
           $urandom_range(0, 15), clr);
    end

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 20 + i, i, 0, 0, 0, 0);
    do_reset("reset_mid");
    step("post_rst", 1, 33, 4, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
